// File: rtl/jseq_pkg.sv
// jseq_pkg: shared types and constants for the jseq_stepper CPU sequencer.
//   state_e         : sequencer FSM states (IDLE, RUN, HALT)
//   Q0..Q3          : phase counter values within one CPU cycle
//   PH_CLK/PH_CLKD  : per-phase lookup of cpu_clk / cpu_clkd (bit index = phase)
//   clamp_step()    : limits a programmed step_max to the last real stage
package jseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Phase:            q3 q2 q1 q0
    localparam logic [3:0] PH_CLK  = 4'b0011;
    localparam logic [3:0] PH_CLKD = 4'b0110;

    // Programmed values past the last stage behave as the last stage.
    function automatic int unsigned clamp_step(input int unsigned step_max,
                                               input int unsigned steps);
        return (step_max >= steps) ? (steps - 1) : step_max;
    endfunction

endpackage

// File: rtl/jseq_phase.sv
// jseq_phase: 2-bit phase counter plus registered 4-phase clock decode.
// Ports:
//   i_clk, i_reset_n    board clock, async active-low reset (q resets to Q3)
//   i_start             load Q0 (first phase of a new CPU cycle)
//   i_hold              keep current phase (ignored when i_start is set)
//   o_q_nxt             phase value being loaded this clock
//   o_boundary          current phase is Q3 (the next edge is a cycle boundary)
//   o_clk/o_clkd        registered CPU clock phases
//   o_clke/o_clks       registered enable (clk|clkd) / set (clk&clkd) windows
module jseq_phase
    import jseq_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic       i_hold,
    output logic [1:0] o_q_nxt,
    output logic       o_boundary,
    output logic       o_clk,
    output logic       o_clkd,
    output logic       o_clke,
    output logic       o_clks
);

    logic [1:0] r_q;
    logic [1:0] w_q_nxt;
    logic       r_clk, r_clkd, r_clke, r_clks;

    always_comb begin
        w_q_nxt = r_q;
        if (i_start)
            w_q_nxt = Q0;
        else if (!i_hold)
            w_q_nxt = r_q + 2'd1;
    end

    // Clocks are decoded from the next phase so they change on the same
    // edge as q, with no combinational path to the outputs. Holding at Q3
    // (idle/halt) therefore parks every clock low.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q    <= Q3;
            r_clk  <= 1'b0;
            r_clkd <= 1'b0;
            r_clke <= 1'b0;
            r_clks <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_clk  <= PH_CLK[w_q_nxt];
            r_clkd <= PH_CLKD[w_q_nxt];
            r_clke <= PH_CLK[w_q_nxt] | PH_CLKD[w_q_nxt];
            r_clks <= PH_CLK[w_q_nxt] & PH_CLKD[w_q_nxt];
        end
    end

    assign o_q_nxt    = w_q_nxt;
    assign o_boundary = (r_q == Q3);
    assign o_clk      = r_clk;
    assign o_clkd     = r_clkd;
    assign o_clke     = r_clke;
    assign o_clks     = r_clks;

endmodule

// File: rtl/jseq_stepper.sv
// jseq_stepper: CPU sequencer - 4-phase clock generator plus one-hot stepper
// advancing one stage per CPU cycle (4 board clocks).
// Parameters: STEPS (2..16) stepper stages, SW index width (2**SW >= STEPS).
// Ports:
//   i_clk, i_reset_n   board clock, async active-low reset
//   i_run              level: keep cycling / halt at next cycle boundary
//   i_restart          pulse: next cycle starts at step 0 (latched until used)
//   i_step_max         last active step index (clamped to STEPS-1)
//   o_cpu_clk/_clkd    CPU clock phases; o_cpu_clke/_clks enable/set windows
//   o_bos              one-hot current step; o_step_idx its binary index
//   o_cycle_start      high during phase 0 of each cycle
//   o_running          FSM is in RUN
// Optional feature macro JSEQ_SINGLE_STEP_EN adds:
//   i_step_req         pulse in HALT (with run=0): execute exactly one cycle
//   o_step_ack         1-clk pulse on the edge returning to HALT afterwards
module jseq_stepper
    import jseq_pkg::*;
#(
    parameter int STEPS = 6,
    parameter int SW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic             i_restart,
    input  logic [SW-1:0]    i_step_max,
    output logic             o_cpu_clk,
    output logic             o_cpu_clkd,
    output logic             o_cpu_clke,
    output logic             o_cpu_clks,
    output logic [STEPS-1:0] o_bos,
    output logic [SW-1:0]    o_step_idx,
    output logic             o_cycle_start,
    output logic             o_running
`ifdef JSEQ_SINGLE_STEP_EN
    ,
    input  logic             i_step_req,
    output logic             o_step_ack
`endif
);

    state_e           r_state, w_state_nxt;
    logic [SW-1:0]    r_step, w_step_nxt;
    logic [SW-1:0]    w_lim, w_next;
    logic             r_restart, w_pend, w_apply;
    logic             w_start, w_hold, w_boundary;
    logic [1:0]       w_q_nxt;
    logic [STEPS-1:0] r_bos, w_bos_nxt;
    logic             r_cycle_start, r_running;
`ifdef JSEQ_SINGLE_STEP_EN
    logic             r_single, w_single_nxt;
    logic             r_ack, w_ack_nxt;
`endif

    jseq_phase u_phase (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (w_start),
        .i_hold     (w_hold),
        .o_q_nxt    (w_q_nxt),
        .o_boundary (w_boundary),
        .o_clk      (o_cpu_clk),
        .o_clkd     (o_cpu_clkd),
        .o_clke     (o_cpu_clke),
        .o_clks     (o_cpu_clks)
    );

    // A restart arriving on the very edge it would be used is honoured then.
    assign w_pend = r_restart | i_restart;
    assign w_lim  = SW'(clamp_step(32'(i_step_max), STEPS));
    // ">=" rather than "==" so lowering step_max below the current step wraps.
    assign w_next = (w_pend || (r_step >= w_lim)) ? '0 : r_step + SW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_start     = 1'b0;
        w_hold      = 1'b1;
        w_apply     = 1'b0;
`ifdef JSEQ_SINGLE_STEP_EN
        w_single_nxt = r_single;
        w_ack_nxt    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (i_run) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                    w_step_nxt  = '0;
                    w_apply     = 1'b1;
                end
            end
            RUN: begin
                if (!w_boundary) begin
                    w_hold = 1'b0;
                end else begin
`ifdef JSEQ_SINGLE_STEP_EN
                    w_single_nxt = 1'b0;
                    w_ack_nxt    = r_single & ~i_run;
`endif
                    if (i_run) begin
                        w_start    = 1'b1;
                        w_step_nxt = w_next;
                        w_apply    = 1'b1;
                    end else begin
                        // q stays at Q3, so clocks park low while halted.
                        w_state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                if (i_run) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                    w_step_nxt  = w_next;
                    w_apply     = 1'b1;
                end
`ifdef JSEQ_SINGLE_STEP_EN
                else if (i_step_req) begin
                    // One cycle in RUN with run=0 falls back to HALT by itself.
                    w_state_nxt  = RUN;
                    w_start      = 1'b1;
                    w_step_nxt   = w_next;
                    w_apply      = 1'b1;
                    w_single_nxt = 1'b1;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_bos_nxt = '0;
        for (int i = 0; i < STEPS; i++)
            w_bos_nxt[i] = (w_state_nxt != IDLE) && (w_step_nxt == SW'(i));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_step        <= '0;
            r_restart     <= 1'b0;
            r_bos         <= '0;
            r_cycle_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_step        <= w_step_nxt;
            r_restart     <= w_pend & ~w_apply;
            r_bos         <= w_bos_nxt;
            r_cycle_start <= (w_state_nxt == RUN) && (w_q_nxt == Q0);
            r_running     <= (w_state_nxt == RUN);
        end
    end

`ifdef JSEQ_SINGLE_STEP_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_single <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_single <= w_single_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    assign o_step_ack = r_ack;
`endif

    assign o_bos         = r_bos;
    assign o_step_idx    = r_step;
    assign o_cycle_start = r_cycle_start;
    assign o_running     = r_running;

endmodule

// File: tb/tb_jseq_stepper.sv
// tb_jseq_stepper: scoreboard bench for jseq_stepper (STEPS=6, SW=4).
// The driver updates a behavioural model every clock and queues the expected
// outputs; a monitor compares each queued entry #1 after the posedge.
module tb_jseq_stepper;

    localparam int STEPS = 6;
    localparam int SW    = 4;

    typedef struct packed {
        logic             clk, clkd, clke, clks;
        logic [STEPS-1:0] bos;
        logic [SW-1:0]    idx;
        logic             cs, running, ack;
    } obs_t;

    logic             clk, reset_n, run, restart;
    logic [SW-1:0]    step_max;
    logic             cpu_clk, cpu_clkd, cpu_clke, cpu_clks;
    logic [STEPS-1:0] bos;
    logic [SW-1:0]    step_idx;
    logic             cycle_start, running;
    logic             step_req, step_ack;

    jseq_stepper #(.STEPS(STEPS), .SW(SW)) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_run         (run),
        .i_restart     (restart),
        .i_step_max    (step_max),
        .o_cpu_clk     (cpu_clk),
        .o_cpu_clkd    (cpu_clkd),
        .o_cpu_clke    (cpu_clke),
        .o_cpu_clks    (cpu_clks),
        .o_bos         (bos),
        .o_step_idx    (step_idx),
        .o_cycle_start (cycle_start),
        .o_running     (running)
`ifdef JSEQ_SINGLE_STEP_EN
        ,
        .i_step_req    (step_req),
        .o_step_ack    (step_ack)
`endif
    );

`ifndef JSEQ_SINGLE_STEP_EN
    assign step_ack = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    obs_t sb[$];

    // Model: mode 0=idle 1=run 2=halt; pos = phase within CPU cycle.
    int m_mode, m_pos, m_step;
    bit m_pend, m_single, m_ack;

    function automatic obs_t sample();
        obs_t o;
        o.clk = cpu_clk; o.clkd = cpu_clkd; o.clke = cpu_clke; o.clks = cpu_clks;
        o.bos = bos; o.idx = step_idx; o.cs = cycle_start; o.running = running;
        o.ack = step_ack;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        bit   act;
        act       = (m_mode == 1);
        o.clk     = act && (m_pos < 2);
        o.clkd    = act && (m_pos == 1 || m_pos == 2);
        o.clke    = o.clk | o.clkd;
        o.clks    = o.clk & o.clkd;
        o.bos     = (m_mode == 0) ? '0 : STEPS'(1 << m_step);
        o.idx     = SW'(m_step);
        o.cs      = act && (m_pos == 0);
        o.running = act;
        o.ack     = m_ack;
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 3; m_step = 0; m_pend = 0; m_single = 0; m_ack = 0;
    endtask

    // Advance the model by the edge that will sample the current inputs.
    task automatic model_tick();
        bit pend_now, ss;
        int lim, nxt;
        m_ack = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
`ifdef JSEQ_SINGLE_STEP_EN
        ss = step_req;
`else
        ss = 0;
`endif
        pend_now = m_pend || restart;
        lim      = (int'(step_max) > STEPS - 1) ? STEPS - 1 : int'(step_max);
        nxt      = (pend_now || m_step >= lim) ? 0 : m_step + 1;
        case (m_mode)
            0: begin
                if (run) begin m_mode = 1; m_pos = 0; m_step = 0; m_pend = 0; end
                else m_pend = pend_now;
            end
            1: begin
                if (m_pos < 3) begin
                    m_pos++; m_pend = pend_now;
                end else if (run) begin
                    m_pos = 0; m_step = nxt; m_pend = 0; m_single = 0;
                end else begin
                    m_mode = 2; m_ack = m_single; m_single = 0; m_pend = pend_now;
                end
            end
            default: begin
                if (run) begin
                    m_mode = 1; m_pos = 0; m_step = nxt; m_pend = 0;
                end else if (ss) begin
                    m_mode = 1; m_pos = 0; m_step = nxt; m_pend = 0; m_single = 1;
                end else begin
                    m_pend = pend_now;
                end
            end
        endcase
    endtask

    // One board clock: predict, queue, move to the next negedge.
    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_tick();
            sb.push_back(model_obs());
            @(negedge clk);
        end
    endtask

    // Run until the model sits in RUN at (step, pos); bounded.
    task automatic wait_at(input int s, input int p, input string name);
        int budget = 200;
        while (!(m_mode == 1 && m_step == s && m_pos == p) && budget > 0) begin
            cyc(); budget--;
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL %s: step %0d phase %0d never reached (at mode=%0d step=%0d)",
                     name, s, p, m_mode, m_step);
        end
    endtask

    task automatic check_now(input string name);
        obs_t a, e;
        a = sample(); e = model_obs();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_now("async_reset");
        cyc(n);
        reset_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation after the clock edge.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = sample();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs@%0t: got clk%b%b%b%b bos=%b idx=%0d cs=%b run=%b ack=%b; expected clk%b%b%b%b bos=%b idx=%0d cs=%b run=%b ack=%b",
                             $time, a.clk, a.clkd, a.clke, a.clks, a.bos, a.idx, a.cs, a.running, a.ack,
                             e.clk, e.clkd, e.clke, e.clks, e.bos, e.idx, e.cs, e.running, e.ack);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; restart = 1'b0; step_max = 4'd5; step_req = 1'b0;
        model_reset();
        @(negedge clk);
        check_now("reset_state");
        cyc(2);
        reset_n = 1'b1;
        cyc(3);                         // idle with run=0 stays parked

        // Full six-step wrap.
        run = 1'b1; step_max = 4'd5;
        cyc(30);

        // Shortened sequence, then an out-of-range limit that clamps.
        step_max = 4'd2;  cyc(16);
        step_max = 4'd9;  cyc(28);
        step_max = 4'd0;  cyc(9);       // permanent step 0
        step_max = 4'd5;

        // Halt request raised mid-cycle takes effect at the boundary.
        wait_at(3, 1, "halt_setup");
        run = 1'b0; cyc(6);
        run = 1'b1; cyc(6);

        // Restart mid-cycle, then restart together with a halt.
        wait_at(2, 2, "restart_setup");
        restart = 1'b1; cyc(); restart = 1'b0;
        cyc(6);
        wait_at(1, 3, "restart_halt_setup");
        restart = 1'b1; run = 1'b0; cyc();
        restart = 1'b0; cyc(4);
        run = 1'b1; cyc(5);

        // Asynchronous reset in the middle of a cycle.
        wait_at(4, 1, "reset_setup");
        do_reset(2);
        cyc(3);

`ifdef JSEQ_SINGLE_STEP_EN
        wait_at(1, 1, "single_setup");
        run = 1'b0; cyc(6);
        step_req = 1'b1; cyc(); step_req = 1'b0;
        cyc(8);
        step_req = 1'b1; run = 1'b1; cyc(); step_req = 1'b0;
        cyc(8);
`endif

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            restart = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) step_max = SW'($urandom_range(0, 15));
            step_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0)
                do_reset($urandom_range(1, 2));
            else
                cyc();
        end
        restart = 1'b0; step_req = 1'b0;
        cyc(2);
        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left, 0 expected", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
